multi_channel_signal_generator: RTL and testbench
=================================================

Name:
multi_channel_signal_generator

Overview:
Synthesizable, parametrised test-stimulus source for the echo-cancellation datapath. It produces NUM_CH independent sample streams, one new sample per sampling period, in one of four modes: pseudo-random LFSR, ramp, square, or constant. It owns its own sampling-period counter and emits a one-cycle valid strobe per sample. Downstream filter and adaptation blocks consume `signal` qualified by `signal_valid`.

Parameters:
DATA_WIDTH, 16, sample width in bits; legal range 2..32.
NUM_CH, 2, number of output channels; legal range ≥1.
CYCLES_PER_SAMPLE, 8192, clk_operation cycles per sample period; legal range ≥1.
HALF_PERIOD, 16, samples per half-cycle of square mode; legal range ≥1.
LFSR_SEED, 32'hACE1_1234, base LFSR seed.

Ports:
clk_operation  input  1  operation clock; all state updates on its rising edge.
rst  input  1  reset, asynchronous, active-high.
enable  input  1  run control; low freezes all state.
mode  input  2  0 = random, 1 = ramp, 2 = square, 3 = constant.
amplitude  input  DATA_WIDTH  magnitude used by square and constant modes.
step  input  DATA_WIDTH  ramp increment per sample.
signal  output  NUM_CH*DATA_WIDTH  channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
signal_valid  output  1  one-cycle strobe; high when `signal` has just updated.
sample_count  output  16  number of samples issued; wraps modulo 2^16.

Behaviour:
- Reset (asynchronous, rst=1): all of the following are forced immediately.
  - Outputs: signal=0, signal_valid=0, sample_count=0.
  - Internal state: period counter=0, ramp accumulators=0, square half-counter=0, square phase=positive.
  - Each channel LFSR loads seed_k = LFSR_SEED ^ ((k+1)*32'h9E37_79B9); if seed_k evaluates to 0, 1 is loaded instead.
- Period counter: width = max(1, clog2(CYCLES_PER_SAMPLE)).
  - On each edge with enable=1, it wraps CYCLES_PER_SAMPLE-1 → 0 and otherwise increments.
  - With enable=0 it holds.
- Tick: a tick is an edge where enable=1 and the counter equals 0.
  - The first tick is therefore the first enabled edge after reset.
  - Ticks are spaced exactly CYCLES_PER_SAMPLE enabled cycles apart.
  - With CYCLES_PER_SAMPLE=1, every enabled edge is a tick.
- On a tick (every channel, in parallel):
  - mode is sampled at the tick edge only; changes between ticks have no effect until the next tick.
  - The LFSR advances one step in every mode, so the random sequence stays mode-independent.
    - Update rule (Galois, right-shift, taps 32'h8020_0003): next = (s>>1) ^ (s[0] ? taps : 0).
  - The ramp accumulator updates as acc <= acc + step, modulo 2^DATA_WIDTH, in every mode.
  - The square half-counter increments. On reaching HALF_PERIOD-1 it wraps to 0 and the phase toggles.
  - signal_k is loaded according to mode:
    - random: low DATA_WIDTH bits of the new LFSR value.
    - ramp: the new acc (acc+step).
    - square: amplitude when the phase is positive, else the two's-complement negation of amplitude (modulo 2^DATA_WIDTH). The phase used is the value before the toggle.
    - constant: amplitude.
  - sample_count increments; signal_valid=1 on the following cycle only.
- Between ticks: signal holds and signal_valid=0.
- Latency: signal and signal_valid become visible in the same cycle, immediately after the tick edge.
- enable deasserted mid-period: the counter holds and resumes where it left off. No tick is lost or duplicated.
- amplitude and step are sampled at the tick edge only.
- Reset mid-operation: all state returns to reset values immediately. After release, the first enabled edge is a tick and the LFSR sequence restarts from seed_k.
- All channels share the counter, mode and controls. Channels differ only in their LFSR state.

Test Plan:
- Reset/idle: rst pulse, enable=0 for 50 cycles → signal=0, signal_valid=0, sample_count=0 throughout.
- Ramp + wrap (CYCLES_PER_SAMPLE=4, mode=1):
  - step=3 → ch0 samples 3,6,9,12,15,18, with valid exactly every 4th cycle.
  - After reset, step=16'hFFFF → 0xFFFF, 0xFFFE, 0xFFFD.
- Square (mode=2, amplitude=100, HALF_PERIOD=2) → 0x0064, 0x0064, 0xFF9C, 0xFF9C, 0x0064. Mode changed mid-period takes effect only at the next tick.
- Random (mode=0, NUM_CH=2) → 1000 samples match the bench Galois model bit-exactly. ch0≠ch1 and neither LFSR reaches 0. After a mid-run reset, the sequence repeats from sample 1.
- Enable gating (CYCLES_PER_SAMPLE=8):
  - Drop enable for 5 cycles at counter=3 → next tick arrives 5 cycles late, sample_count has no gap.
  - rst asserted in the cycle of a tick → signal=0 and no valid pulse.
- Constant + CYCLES_PER_SAMPLE=1 → signal=amplitude and signal_valid=1 every enabled cycle. sample_count wraps 0xFFFF→0x0000.

Source files
------------

// File: rtl/multi_channel_signal_generator.sv
// Parametrised multi-channel test-stimulus source: per-channel LFSR, ramp, square or
// constant samples, one new sample per CYCLES_PER_SAMPLE enabled clocks.
module multi_channel_signal_generator #(
  parameter int          DATA_WIDTH        = 16,
  parameter int          NUM_CH            = 2,
  parameter int          CYCLES_PER_SAMPLE = 8192,
  parameter int          HALF_PERIOD       = 16,
  parameter logic [31:0] LFSR_SEED         = 32'hACE1_1234
) (
  input  logic                         clk_operation,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [1:0]                   mode,
  input  logic [DATA_WIDTH-1:0]        amplitude,
  input  logic [DATA_WIDTH-1:0]        step,
  output logic [NUM_CH*DATA_WIDTH-1:0] signal,
  output logic                         signal_valid,
  output logic [15:0]                  sample_count
);

  // Handshake: signal_valid is a one-cycle strobe with no ready/backpressure; a
  // consumer must capture signal in the cycle signal_valid is high, and signal holds
  // its value until the next strobe.

  localparam int CW = (CYCLES_PER_SAMPLE > 1) ? $clog2(CYCLES_PER_SAMPLE) : 1;
  localparam int HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CYCLES_PER_SAMPLE - 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_PERIOD - 1);
  localparam logic [31:0]   TAPS      = 32'h8020_0003;

  typedef enum logic [1:0] {
    MODE_RANDOM = 2'd0,
    MODE_RAMP   = 2'd1,
    MODE_SQUARE = 2'd2,
    MODE_CONST  = 2'd3
  } mode_e;

  logic [CW-1:0]         period_cnt;
  logic                  tick;
  logic [HW-1:0]         half_cnt;
  logic                  phase_neg;
  logic [DATA_WIDTH-1:0] square_val;

  assign tick = enable && (period_cnt == '0);

  always_ff @(posedge clk_operation or posedge rst) begin
    if (rst) begin
      period_cnt <= '0;
    end else if (enable) begin
      period_cnt <= (period_cnt == CNT_LAST) ? '0 : period_cnt + CW'(1);
    end
  end

  // The phase used for the current sample is the one before any toggle.
  assign square_val = phase_neg ? ((~amplitude) + DATA_WIDTH'(1)) : amplitude;

  always_ff @(posedge clk_operation or posedge rst) begin
    if (rst) begin
      half_cnt  <= '0;
      phase_neg <= 1'b0;
    end else if (tick) begin
      if (half_cnt == HALF_LAST) begin
        half_cnt  <= '0;
        phase_neg <= ~phase_neg;
      end else begin
        half_cnt <= half_cnt + HW'(1);
      end
    end
  end

  always_ff @(posedge clk_operation or posedge rst) begin
    if (rst) begin
      signal_valid <= 1'b0;
      sample_count <= 16'd0;
    end else begin
      signal_valid <= tick;
      if (tick) begin
        sample_count <= sample_count + 16'd1;
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    localparam logic [31:0] SEED_RAW = LFSR_SEED ^ (32'(k + 1) * 32'h9E37_79B9);
    localparam logic [31:0] SEED     = (SEED_RAW == 32'd0) ? 32'd1 : SEED_RAW;

    logic [31:0]           lfsr;
    logic [31:0]           lfsr_next;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] acc_next;
    logic [DATA_WIDTH-1:0] sample;
    logic [DATA_WIDTH-1:0] sig_q;

    // LFSR and ramp advance on every tick regardless of mode.
    assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 32'd0);
    assign acc_next  = acc + step;

    always_comb begin
      sample = amplitude;
      case (mode)
        MODE_RANDOM: sample = lfsr_next[DATA_WIDTH-1:0];
        MODE_RAMP:   sample = acc_next;
        MODE_SQUARE: sample = square_val;
        MODE_CONST:  sample = amplitude;
        default:     sample = amplitude;
      endcase
    end

    always_ff @(posedge clk_operation or posedge rst) begin
      if (rst) begin
        lfsr  <= SEED;
        acc   <= '0;
        sig_q <= '0;
      end else if (tick) begin
        lfsr  <= lfsr_next;
        acc   <= acc_next;
        sig_q <= sample;
      end
    end

    assign signal[k*DATA_WIDTH +: DATA_WIDTH] = sig_q;
  end

endmodule

// File: tb/tb_multi_channel_signal_generator.sv
// Directed bench for multi_channel_signal_generator: a reference model pushes expected
// samples to a queue on predicted ticks; each observed valid strobe pops and compares.
module tb_multi_channel_signal_generator;

  localparam int CPS = 4;
  localparam int HP  = 2;

  logic        clk_operation = 1'b0;
  always #5 clk_operation = ~clk_operation;

  // Main instance (CYCLES_PER_SAMPLE=4, HALF_PERIOD=2)
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] amplitude = 16'd0;
  logic [15:0] step = 16'd0;
  logic [31:0] signal;
  logic        signal_valid;
  logic [15:0] sample_count;

  // Second instance (CYCLES_PER_SAMPLE=1) for constant mode and count wrap
  logic        rst1 = 1'b1;
  logic        en1 = 1'b1;
  logic [1:0]  mode1 = 2'd3;
  logic [15:0] amp1 = 16'h1234;
  logic [15:0] step1 = 16'd0;
  logic [31:0] signal1;
  logic        valid1;
  logic [15:0] count1;

  multi_channel_signal_generator #(
    .DATA_WIDTH(16), .NUM_CH(2), .CYCLES_PER_SAMPLE(CPS), .HALF_PERIOD(HP),
    .LFSR_SEED(32'hACE1_1234)
  ) dut (
    .clk_operation(clk_operation), .rst(rst), .enable(enable), .mode(mode),
    .amplitude(amplitude), .step(step), .signal(signal),
    .signal_valid(signal_valid), .sample_count(sample_count)
  );

  multi_channel_signal_generator #(
    .DATA_WIDTH(16), .NUM_CH(2), .CYCLES_PER_SAMPLE(1), .HALF_PERIOD(16),
    .LFSR_SEED(32'hACE1_1234)
  ) dut1 (
    .clk_operation(clk_operation), .rst(rst1), .enable(en1), .mode(mode1),
    .amplitude(amp1), .step(step1), .signal(signal1),
    .signal_valid(valid1), .sample_count(count1)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [47:0] exp_q[$];
  logic [31:0] got_log[$];
  int          tick_log[$];
  int          cyc_n = 0;
  int          tick_at = 0;
  int          eq_count = 0;

  // Reference model state
  int          m_cnt;
  logic [31:0] m_lfsr [2];
  logic [15:0] m_acc;
  int          m_hcnt;
  logic        m_neg;
  logic [31:0] m_sig;
  logic [15:0] m_samples;
  logic        m_valid;

  function automatic logic [31:0] galois(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'd0);
  endfunction

  function automatic logic [31:0] seed_of(input int k);
    logic [31:0] s;
    s = 32'hACE1_1234 ^ (32'(k + 1) * 32'h9E37_79B9);
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    for (int k = 0; k < 2; k++) m_lfsr[k] = seed_of(k);
    m_acc = 16'd0;
    m_hcnt = 0;
    m_neg = 1'b0;
    m_sig = 32'd0;
    m_samples = 16'd0;
    m_valid = 1'b0;
  endtask

  // Predicts the effect of the coming rising edge from the inputs currently driven.
  task automatic model_edge();
    logic [15:0] v;
    m_valid = 1'b0;
    if (enable) begin
      if (m_cnt == 0) begin
        m_valid = 1'b1;
        m_acc = m_acc + step;
        for (int k = 0; k < 2; k++) begin
          m_lfsr[k] = galois(m_lfsr[k]);
          case (mode)
            2'd0:    v = m_lfsr[k][15:0];
            2'd1:    v = m_acc;
            2'd2:    v = m_neg ? (16'd0 - amplitude) : amplitude;
            default: v = amplitude;
          endcase
          m_sig[k*16 +: 16] = v;
        end
        if (m_hcnt == HP - 1) begin
          m_hcnt = 0;
          m_neg = ~m_neg;
        end else begin
          m_hcnt++;
        end
        m_samples = m_samples + 16'd1;
        exp_q.push_back({m_samples, m_sig});
      end
      m_cnt = (m_cnt == CPS - 1) ? 0 : m_cnt + 1;
    end
  endtask

  // One clock: predict, let the edge happen, check on the following falling edge.
  task automatic cyc();
    logic [47:0] e;
    model_edge();
    @(posedge clk_operation);
    @(negedge clk_operation);
    cyc_n++;
    chk("valid", signal_valid, m_valid);
    if (signal_valid) begin
      tick_at = cyc_n;
      tick_log.push_back(cyc_n);
      got_log.push_back(signal);
      if (signal[15:0] == signal[31:16]) eq_count++;
      chk("queue_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sample", {sample_count, signal}, e);
      end
    end
    chk("hold", {sample_count, signal}, {m_samples, m_sig});
  endtask

  task automatic run_ticks(input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n * CPS * 4 + 40 && seen < n; i++) begin
      cyc();
      if (signal_valid) seen++;
    end
    chk("tick_budget", seen, n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    exp_q.delete();
    #1;
    chk("rst_async", {signal_valid, sample_count, signal}, 64'd0);
    @(posedge clk_operation);
    @(negedge clk_operation);
    chk("rst_held", {signal_valid, sample_count, signal}, 64'd0);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ramp_exp [6];
    logic [15:0] dec_exp [3];
    logic [15:0] sq_exp [5];
    logic [31:0] ref8 [8];
    logic [31:0] s0, s1;
    int          t0;

    ramp_exp = '{16'd3, 16'd6, 16'd9, 16'd12, 16'd15, 16'd18};
    dec_exp  = '{16'hFFFF, 16'hFFFE, 16'hFFFD};
    sq_exp   = '{16'h0064, 16'h0064, 16'hFF9C, 16'hFF9C, 16'h0064};

    @(negedge clk_operation);

    // Reset then idle with enable low
    do_reset();
    enable = 1'b0;
    repeat (50) cyc();

    // Ramp, step=3
    do_reset();
    mode = 2'd1; step = 16'd3; enable = 1'b1;
    got_log.delete(); tick_log.delete();
    run_ticks(6);
    for (int i = 0; i < 6; i++) chk("ramp_ch0", got_log[i][15:0], ramp_exp[i]);
    for (int i = 1; i < 6; i++) chk("ramp_spacing", tick_log[i] - tick_log[i-1], 4);

    // Ramp wrap, step=0xFFFF
    do_reset();
    step = 16'hFFFF;
    got_log.delete();
    run_ticks(3);
    for (int i = 0; i < 3; i++) chk("ramp_wrap_ch0", got_log[i][15:0], dec_exp[i]);

    // Square, then a mode change between ticks
    do_reset();
    mode = 2'd2; amplitude = 16'd100;
    got_log.delete();
    run_ticks(5);
    for (int i = 0; i < 5; i++) chk("square_ch0", got_log[i][15:0], sq_exp[i]);
    mode = 2'd3; amplitude = 16'd7;
    cyc();
    chk("mode_change_hold", signal[15:0], 16'h0064);
    run_ticks(1);
    chk("mode_change_next", signal, {16'd7, 16'd7});

    // Enable dropped for 5 cycles with the counter at 3
    do_reset();
    mode = 2'd1; step = 16'd1;
    run_ticks(1);
    t0 = tick_at;
    cyc(); cyc();
    enable = 1'b0;
    repeat (5) cyc();
    enable = 1'b1;
    run_ticks(1);
    chk("gate_delay", tick_at - t0, 9);
    chk("gate_count", sample_count, 16'd2);
    chk("gate_ramp", signal[15:0], 16'd2);

    // Reset asserted in the cycle of a tick
    cyc(); cyc(); cyc();
    do_reset();
    chk("rst_tick_no_valid", signal_valid, 1'b0);
    chk("rst_tick_signal", signal, 32'd0);

    // Random mode, 1000 samples, then reset mid-period and restart
    do_reset();
    mode = 2'd0;
    eq_count = 0;
    run_ticks(1000);
    chk("rand_channels_differ", 64'(eq_count < 4), 64'd1);
    s0 = seed_of(0);
    s1 = seed_of(1);
    for (int i = 0; i < 8; i++) begin
      s0 = galois(s0);
      s1 = galois(s1);
      ref8[i] = {s1[15:0], s0[15:0]};
    end
    cyc();
    do_reset();
    got_log.delete();
    run_ticks(8);
    for (int i = 0; i < 8; i++) chk("rand_restart", got_log[i], ref8[i]);
    enable = 1'b0;

    // Constant mode with one cycle per sample, across the sample_count wrap
    rst1 = 1'b0;
    for (int i = 1; i <= 65538; i++) begin
      @(posedge clk_operation);
      @(negedge clk_operation);
      chk("const_cps1", {valid1, count1, signal1}, {1'b1, 16'(i), amp1, amp1});
      if (i == 65536) chk("count_wrap", count1, 16'h0000);
    end
    en1 = 1'b0;
    repeat (2) begin
      @(posedge clk_operation);
      @(negedge clk_operation);
      chk("const_disabled", {valid1, count1}, {1'b0, 16'd2});
    end
    en1 = 1'b1;
    @(posedge clk_operation);
    @(negedge clk_operation);
    chk("const_resume", {valid1, count1}, {1'b1, 16'd3});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
